// File: rtl/vga_grid_pkg.sv
// vga_grid_pkg
// Shared constants for the VGA game-grid renderer: cell codes, grid
// geometry, playfield address width, and the row/col to address helper.
package vga_grid_pkg;

  localparam int GRID_W     = 40;  // cells per row
  localparam int GRID_H     = 30;  // cells per column
  localparam int CELL_SHIFT = 4;   // 16x16 pixel cells
  localparam int ADDR_W     = 11;  // 40*30 = 1200 cells, max index 1199

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_BODY  = 2'd1;
  localparam logic [1:0] CELL_HEAD  = 2'd2;
  localparam logic [1:0] CELL_APPLE = 2'd3;

  // row*40 + col built from two shifts and adds, so no multiplier is
  // inferred. The shift amounts hard-code a 40-cell row.
  function automatic logic [ADDR_W-1:0] cell_index(input logic [ADDR_W-1:0] row,
                                                   input logic [ADDR_W-1:0] col);
    return (row << 5) + (row << 3) + col;
  endfunction

endpackage

// File: rtl/vga_grid_renderer_sync_delay.sv
// sync_delay
// Fixed-depth shift register for an active-low sync strobe. It resets to
// the inactive level (1), so a flushed pipeline never emits a sync pulse.
// Ports:
//   clk   in  1 : clock
//   reset in  1 : synchronous, active-high
//   d     in  1 : sync input
//   q     out 1 : d delayed by DEPTH clocks
module sync_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      taps_reg <= '1;
    end else begin
      taps_reg <= {taps_reg[DEPTH-2:0], d};
    end
  end

  assign q = taps_reg[DEPTH-1];

endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer
// Turns tracker raster coordinates into a playfield cell address, reads the
// cell code back from a synchronous RAM and maps it to an RGB444 colour. The
// border ring of the grid is painted a fixed colour whatever the RAM holds.
// Colour and syncs leave together, three clocks after the tracker inputs.
// Ports:
//   clock_25          in  1  : pixel clock
//   reset             in  1  : synchronous, active-high
//   X, Y              in  10 : raster column / line
//   display_area      in  1  : (X,Y) is visible
//   h_sync_in         in  1  : active-low hsync from tracker
//   v_sync_in         in  1  : active-low vsync from tracker
//   cell_addr         out 11 : playfield RAM read address
//   cell_data         in  2  : RAM read data, one clock after cell_addr
//   vga_r/vga_g/vga_b out 4  : pixel colour
//   h_sync, v_sync    out 1  : syncs aligned to the colour stream
//   frame_pulse       out 1  : one clock per frame, on the vsync falling edge
module vga_grid_renderer #(
  parameter logic [9:0]  H_OFFSET   = 10'd48,
  parameter logic [9:0]  V_OFFSET   = 10'd34,
  parameter int          CELL_SHIFT = vga_grid_pkg::CELL_SHIFT,
  parameter int          GRID_W     = vga_grid_pkg::GRID_W,
  parameter int          GRID_H     = vga_grid_pkg::GRID_H,
  parameter logic [11:0] COL_EMPTY  = 12'h000,
  parameter logic [11:0] COL_BODY   = 12'h0A0,
  parameter logic [11:0] COL_HEAD   = 12'h0F0,
  parameter logic [11:0] COL_APPLE  = 12'hF00,
  parameter logic [11:0] COL_BORDER = 12'h888
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        display_area,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [10:0] cell_addr,
  input  logic [1:0]  cell_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        h_sync,
  output logic        v_sync,
  output logic        frame_pulse
);

  import vga_grid_pkg::*;

  // Outside the visible area these wrap around; nothing downstream uses
  // them then, because de/border are forced low and the address is held.
  logic [9:0] px;
  logic [9:0] py;
  logic [9:0] col;
  logic [9:0] row;
  logic       on_border;

  assign px  = X - H_OFFSET;
  assign py  = Y - V_OFFSET;
  assign col = px >> CELL_SHIFT;
  assign row = py >> CELL_SHIFT;

  assign on_border = (col == 10'd0) || (col == 10'(GRID_W - 1)) ||
                     (row == 10'd0) || (row == 10'(GRID_H - 1));

  // Stage 1: address, visibility and border flag.
  logic [ADDR_W-1:0] cell_addr_reg;
  logic              de1_reg;
  logic              border1_reg;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      cell_addr_reg <= '0;
      de1_reg       <= 1'b0;
      border1_reg   <= 1'b0;
    end else begin
      de1_reg     <= display_area;
      border1_reg <= display_area && on_border;
      if (display_area) begin
        cell_addr_reg <= cell_index({1'b0, row}, {1'b0, col});
      end
    end
  end

  assign cell_addr = cell_addr_reg;

  // Stage 2: flags wait here while the RAM produces cell_data.
  logic de2_reg;
  logic border2_reg;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      de2_reg     <= 1'b0;
      border2_reg <= 1'b0;
    end else begin
      de2_reg     <= de1_reg;
      border2_reg <= border1_reg;
    end
  end

  // Stage 3: colour lookup. Border takes priority over the cell contents.
  logic [11:0] rgb_reg;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      rgb_reg <= 12'h000;
    end else if (!de2_reg) begin
      rgb_reg <= 12'h000;
    end else if (border2_reg) begin
      rgb_reg <= COL_BORDER;
    end else begin
      case (cell_data)
        CELL_EMPTY: rgb_reg <= COL_EMPTY;
        CELL_BODY:  rgb_reg <= COL_BODY;
        CELL_HEAD:  rgb_reg <= COL_HEAD;
        default:    rgb_reg <= COL_APPLE;
      endcase
    end
  end

  assign vga_r = rgb_reg[11:8];
  assign vga_g = rgb_reg[7:4];
  assign vga_b = rgb_reg[3:0];

  // Syncs ride three flops, matching the three colour stages above.
  sync_delay #(.DEPTH(3)) u_hs_delay (
    .clk   (clock_25),
    .reset (reset),
    .d     (h_sync_in),
    .q     (h_sync)
  );

  sync_delay #(.DEPTH(3)) u_vs_delay (
    .clk   (clock_25),
    .reset (reset),
    .d     (v_sync_in),
    .q     (v_sync)
  );

  // Frame pulse on the falling edge of v_sync_in. vs_armed_reg only sets
  // once v_sync_in has been seen high after reset, so leaving reset while
  // vsync is already low cannot produce a pulse.
  logic vs_prev_reg;
  logic vs_armed_reg;
  logic frame_pulse_reg;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      vs_prev_reg     <= 1'b1;
      vs_armed_reg    <= 1'b0;
      frame_pulse_reg <= 1'b0;
    end else begin
      vs_prev_reg     <= v_sync_in;
      vs_armed_reg    <= vs_armed_reg | v_sync_in;
      frame_pulse_reg <= vs_armed_reg && vs_prev_reg && !v_sync_in;
    end
  end

  assign frame_pulse = frame_pulse_reg;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer
// Directed bench for vga_grid_renderer with a small playfield RAM model and
// a shortened raster tracker for the full-frame sync/pulse checks.
module tb_vga_grid_renderer;

  logic        clock_25;
  logic        reset;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        display_area;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [10:0] cell_addr;
  logic [1:0]  cell_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        h_sync;
  logic        v_sync;
  logic        frame_pulse;
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;

  logic [1:0] ram [0:2047];

  vga_grid_renderer dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .X            (X),
    .Y            (Y),
    .display_area (display_area),
    .h_sync_in    (h_sync_in),
    .v_sync_in    (v_sync_in),
    .cell_addr    (cell_addr),
    .cell_data    (cell_data),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .frame_pulse  (frame_pulse)
  );

  assign rgb = {vga_r, vga_g, vga_b};

  initial clock_25 = 1'b0;
  always #20 clock_25 = ~clock_25;

  // Playfield RAM: synchronous read, one clock of latency.
  always @(posedge clock_25) cell_data <= ram[cell_addr];

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one visible pixel for a single clock, then blank.
  task automatic pix(input string tag, input int x, input int y,
                     input logic [10:0] exp_addr, input logic [11:0] exp_rgb);
    X = 10'(x);
    Y = 10'(y);
    display_area = 1'b1;
    tick();
    chk({tag, " addr"}, 32'(cell_addr), 32'(exp_addr));
    display_area = 1'b0;
    tick();
    tick();
    chk({tag, " rgb"}, 32'(rgb), 32'(exp_rgb));
  endtask

  logic hs_h [0:2];
  logic vs_h [0:2];
  int   fp_cnt;
  int   hs_bad;
  int   vs_bad;

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 2'd0;
    ram[81]   = 2'd2;  // col 1,  row 2  : head
    ram[122]  = 2'd1;  // col 2,  row 3  : body
    ram[123]  = 2'd0;  // col 3,  row 3  : empty
    ram[205]  = 2'd3;  // col 5,  row 5  : apple
    ram[0]    = 2'd3;  // col 0,  row 0  : border corner
    ram[1199] = 2'd3;  // col 39, row 29 : border corner
    ram[1180] = 2'd1;  // col 20, row 29 : bottom border

    // Reset with arbitrary, active-looking inputs.
    reset        = 1'b1;
    X            = 10'd65;
    Y            = 10'd67;
    display_area = 1'b1;
    h_sync_in    = 1'b0;
    v_sync_in    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset rgb", 32'(rgb), 32'h000);
      chk("reset h_sync", 32'(h_sync), 32'd1);
      chk("reset v_sync", 32'(v_sync), 32'd1);
      chk("reset frame_pulse", 32'(frame_pulse), 32'd0);
      chk("reset cell_addr", 32'(cell_addr), 32'd0);
    end

    // Release while v_sync_in is already low: no frame pulse allowed.
    reset        = 1'b0;
    display_area = 1'b0;
    h_sync_in    = 1'b1;
    tick();
    chk("post-reset rgb", 32'(rgb), 32'h000);
    chk("post-reset h_sync", 32'(h_sync), 32'd1);
    chk("post-reset v_sync", 32'(v_sync), 32'd1);
    chk("post-reset frame_pulse", 32'(frame_pulse), 32'd0);
    tick();
    chk("release fp c2", 32'(frame_pulse), 32'd0);
    tick();
    chk("release fp c3", 32'(frame_pulse), 32'd0);
    chk("release v_sync low", 32'(v_sync), 32'd0);
    v_sync_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("v_sync back high", 32'(v_sync), 32'd1);

    // A genuine falling edge gives exactly one pulse clock.
    v_sync_in = 1'b0;
    tick();
    chk("fall fp high", 32'(frame_pulse), 32'd1);
    tick();
    chk("fall fp low", 32'(frame_pulse), 32'd0);
    v_sync_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Cell colours and border override.
    pix("head c1r2", 48 + 17, 34 + 33, 11'd81, 12'h0F0);
    pix("body c2r3", 80, 82, 11'd122, 12'h0A0);
    pix("empty c3r3", 96, 82, 11'd123, 12'h000);
    pix("apple c5r5", 128, 114, 11'd205, 12'hF00);
    pix("border c0r0", 48, 34, 11'd0, 12'h888);
    pix("border c39r29", 672, 498, 11'd1199, 12'h888);
    pix("border c20r29", 368, 498, 11'd1180, 12'h888);

    // Blanked input: address held, RAM still returns an apple, colour 0.
    pix("apple again", 128, 114, 11'd205, 12'hF00);
    X = 10'd200;
    Y = 10'd300;
    display_area = 1'b0;
    tick();
    chk("blank addr hold", 32'(cell_addr), 32'd205);
    tick();
    tick();
    chk("blank rgb", 32'(rgb), 32'h000);
    chk("blank cell_data", 32'(cell_data), 32'd3);

    // Shortened raster: 100 clocks/line, 40 lines/frame, starting on line 2
    // so both vsync falls (line 0) lie inside the two-frame run.
    for (int i = 0; i < 3; i++) begin
      hs_h[i] = 1'b1;
      vs_h[i] = 1'b1;
    end
    fp_cnt = 0;
    hs_bad = 0;
    vs_bad = 0;
    for (int n = 0; n < 8000; n++) begin
      int x;
      int y;
      x = n % 100;
      y = (n / 100 + 2) % 40;
      X            = 10'(x);
      Y            = 10'(y);
      h_sync_in    = !(x < 10);
      v_sync_in    = !(y < 2);
      display_area = (x >= 48) && (y >= 34);
      tick();
      hs_h[2] = hs_h[1];
      hs_h[1] = hs_h[0];
      hs_h[0] = h_sync_in;
      vs_h[2] = vs_h[1];
      vs_h[1] = vs_h[0];
      vs_h[0] = v_sync_in;
      if (h_sync !== hs_h[2]) hs_bad++;
      if (v_sync !== vs_h[2]) vs_bad++;
      if (frame_pulse === 1'b1) fp_cnt++;
    end
    chk("frame h_sync misaligned clocks", 32'(hs_bad), 32'd0);
    chk("frame v_sync misaligned clocks", 32'(vs_bad), 32'd0);
    chk("frame_pulse clocks in 2 frames", 32'(fp_cnt), 32'd2);

    // Reset in the middle of a visible line with h_sync_in low.
    h_sync_in    = 1'b0;
    v_sync_in    = 1'b1;
    X            = 10'd65;
    Y            = 10'd67;
    display_area = 1'b1;
    tick();
    tick();
    tick();
    chk("midline rgb before", 32'(rgb), 32'h0F0);
    chk("midline h_sync before", 32'(h_sync), 32'd0);
    reset = 1'b1;
    tick();
    chk("midline reset rgb", 32'(rgb), 32'h000);
    chk("midline reset h_sync", 32'(h_sync), 32'd1);
    chk("midline reset cell_addr", 32'(cell_addr), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midline rel c1 rgb", 32'(rgb), 32'h000);
    chk("midline rel c1 h_sync", 32'(h_sync), 32'd1);
    chk("midline rel c1 addr", 32'(cell_addr), 32'd81);
    tick();
    chk("midline rel c2 rgb", 32'(rgb), 32'h000);
    tick();
    chk("midline rel c3 rgb", 32'(rgb), 32'h0F0);
    chk("midline rel c3 h_sync", 32'(h_sync), 32'd0);
    chk("midline fp", 32'(frame_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
